// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer for a big-endian, word-wide data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are lane-extracted and extended.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_WAIT  = 3'd1;
    localparam logic [2:0] S_RMW_WAIT = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;

    logic [1:0]  bytes_m1;
    logic [32:0] last_addr;
    logic        bad_req;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] ext_data;
    logic [31:0] merged;

    // Last byte touched, computed one bit wider so addresses near 2^32 cannot wrap into range.
    always_comb begin
        case (req_size)
            2'b00:   bytes_m1 = 2'd0;
            2'b01:   bytes_m1 = 2'd1;
            default: bytes_m1 = 2'd3;
        endcase
        last_addr = {1'b0, req_addr} + {31'b0, bytes_m1};
        bad_req   = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (last_addr >= 33'(MEM_BYTES));
    end

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        case (req_addr[1:0])
            2'd0:    lane8 = mem_rdata[31:24];
            2'd1:    lane8 = mem_rdata[23:16];
            2'd2:    lane8 = mem_rdata[15:8];
            default: lane8 = mem_rdata[7:0];
        endcase
        lane16 = req_addr[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        case (req_size)
            2'b00:   ext_data = {{24{req_signed & lane8[7]}}, lane8};
            2'b01:   ext_data = {{16{req_signed & lane16[15]}}, lane16};
            default: ext_data = mem_rdata;
        endcase

        merged = mem_rdata;
        if (req_size == 2'b00) begin
            case (req_addr[1:0])
                2'd0:    merged[31:24] = req_wdata[7:0];
                2'd1:    merged[23:16] = req_wdata[7:0];
                2'd2:    merged[15:8]  = req_wdata[7:0];
                default: merged[7:0]   = req_wdata[7:0];
            endcase
        end else if (req_addr[1]) begin
            merged[15:0] = req_wdata[15:0];
        end else begin
            merged[31:16] = req_wdata[15:0];
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a latch behind.
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    load_data_d = 32'h0;
                    if (bad_req) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        fault_d    = 1'b0;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (!req_write) begin
                            state_d = S_RD_WAIT;
                        end else if (req_size == 2'b10) begin
                            mem_wdata_d = req_wdata;
                            mem_we_d    = 1'b1;
                            state_d     = S_WR;
                        end else begin
                            state_d = S_RMW_WAIT;
                        end
                    end
                end
            end
            S_RD_WAIT: begin
                load_data_d = ext_data;
                state_d     = S_DONE;
            end
            S_RMW_WAIT: begin
                mem_wdata_d = merged;
                mem_we_d    = 1'b1;
                state_d     = S_WR;
            end
            S_WR: begin
                mem_we_d = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset clears every output flop asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
            load_data_q <= 32'h0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    assign stall     = req_valid & (state_q != S_DONE);
    assign load_data = load_data_q;
    assign fault     = fault_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan steps then random requests, checked
// against a byte-array big-endian memory model with arithmetic fault rules.
module tb_mem_access_unit;

    localparam int unsigned MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic [31:0] load_data;
    logic        fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_fail = 0;

    bit [31:0]    mem [MEM_BYTES/4];
    byte unsigned ref_mem [MEM_BYTES];

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .fault(fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int unsigned a);
        int unsigned b = a & ~32'd3;
        return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
    endfunction

    // Issue one request, follow it to DONE, and compare against the model.
    task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got_ld);
        int unsigned  bytes;
        bit           bad;
        logic [31:0]  exp_ld, exp_word, cap_wd, cap_a;
        int           exp_stall, n, we_cnt;

        bytes  = (sz == 2'b11) ? 0 : (1 << sz);
        bad    = (sz == 2'b11) || (a % bytes != 0) || (longint'(a) + bytes > MEM_BYTES);
        exp_ld = 32'h0;
        exp_word = 32'h0;
        if (!bad && !w) begin
            for (int i = 0; i < int'(bytes); i++) exp_ld = (exp_ld << 8) | 32'(ref_mem[int'(a) + i]);
            if (sg && bytes < 4 && exp_ld[8*bytes-1]) exp_ld = exp_ld | (32'hFFFF_FFFF << (8*bytes));
        end else if (!bad) begin
            for (int i = 0; i < int'(bytes); i++)
                ref_mem[int'(a) + i] = 8'(wd >> (8 * (int'(bytes) - 1 - i)));
            exp_word = ref_word(a);
        end
        exp_stall = bad ? 1 : (!w ? 2 : (sz == 2'b10 ? 2 : 3));

        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        #1;
        n = 0; we_cnt = 0; cap_wd = 32'h0; cap_a = 32'h0;
        while (stall === 1'b1 && n < 12) begin
            n++;
            if (mem_we === 1'b1) begin
                we_cnt++;
                cap_wd = mem_wdata;
                cap_a  = mem_addr;
            end
            @(negedge clk); #1;
        end
        got_ld = load_data;
        check("stall_cycles", 32'(n), 32'(exp_stall));
        check("fault", {31'b0, fault}, {31'b0, bad});
        check("load_data", load_data, exp_ld);
        check("we_pulses", 32'(we_cnt), (w && !bad) ? 32'd1 : 32'd0);
        check("we_in_done", {31'b0, mem_we}, 32'd0);
        if (w && !bad) begin
            check("store_wdata", cap_wd, exp_word);
            check("store_addr", cap_a, a & ~32'd3);
        end
        req_valid = 1'b0;
    endtask

    task automatic mem_compare(input string tag);
        int bad_words = 0;
        for (int i = 0; i < int'(MEM_BYTES/4); i++)
            if (mem[i] !== ref_word(4*i)) bad_words++;
        check(tag, 32'(bad_words), 32'd0);
    endtask

    initial begin
        logic [31:0] ld;
        bit          seen_we;

        // Reset state
        #12;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        @(negedge clk); resetn = 1'b1;

        // Word load
        do_req(1, 2'b10, 0, 32'h08, 32'h11223344, ld);
        do_req(0, 2'b10, 0, 32'h08, 32'h0, ld);
        check("lw_const", ld, 32'h11223344);

        // Sub-word loads
        do_req(1, 2'b10, 0, 32'h10, 32'h8899AABB, ld);
        do_req(0, 2'b00, 1, 32'h11, 32'h0, ld);  check("lb_const",  ld, 32'hFFFFFF99);
        do_req(0, 2'b00, 0, 32'h11, 32'h0, ld);  check("lbu_const", ld, 32'h00000099);
        do_req(0, 2'b01, 1, 32'h12, 32'h0, ld);  check("lh_const",  ld, 32'hFFFFAABB);
        do_req(0, 2'b01, 0, 32'h10, 32'h0, ld);  check("lhu_const", ld, 32'h00008899);

        // Byte store RMW, then halfword and word stores
        do_req(1, 2'b10, 0, 32'h0C, 32'h11223344, ld);
        do_req(1, 2'b00, 0, 32'h0E, 32'h000000CC, ld);
        do_req(0, 2'b10, 0, 32'h0C, 32'h0, ld);  check("sb_const", ld, 32'h1122CC44);
        do_req(1, 2'b10, 0, 32'h0C, 32'h11223344, ld);
        do_req(1, 2'b01, 0, 32'h0C, 32'h0000BEEF, ld);
        do_req(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, ld);
        do_req(0, 2'b10, 0, 32'h0C, 32'h0, ld);  check("sh_const", ld, 32'hBEEF3344);
        do_req(0, 2'b10, 0, 32'h20, 32'h0, ld);  check("sw_const", ld, 32'hDEADBEEF);

        // Faults
        do_req(0, 2'b10, 0, 32'h06, 32'h0, ld);
        do_req(0, 2'b01, 1, 32'h03, 32'h0, ld);
        do_req(0, 2'b11, 0, 32'h40, 32'h0, ld);
        do_req(1, 2'b10, 0, MEM_BYTES - 2, 32'hCAFEF00D, ld);
        do_req(1, 2'b01, 0, MEM_BYTES - 2, 32'h0000F00D, ld);
        do_req(0, 2'b10, 0, 32'hFFFF_FFFC, 32'h0, ld);
        mem_compare("mem_after_faults");

        // Reset while a byte store sits in WR
        @(negedge clk);
        req_write = 1; req_size = 2'b00; req_signed = 0; req_addr = 32'h0E; req_wdata = 32'h55;
        req_valid = 1'b1;
        seen_we = 0;
        for (int i = 0; i < 6 && !seen_we; i++) begin
            #1;
            if (mem_we === 1'b1) seen_we = 1;
            else @(negedge clk);
        end
        check("rst_reached_wr", {31'b0, seen_we}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_we_drop", {31'b0, mem_we}, 32'd0);
        check("rst_stall_follows_1", {31'b0, stall}, 32'd1);
        check("rst_wdata_clr", mem_wdata, 32'h0);
        req_valid = 1'b0;
        #1;
        check("rst_stall_follows_0", {31'b0, stall}, 32'd0);
        @(negedge clk); @(negedge clk); resetn = 1'b1;
        mem_compare("mem_after_abort");
        do_req(0, 2'b10, 0, 32'h0C, 32'h0, ld);  check("post_rst_lw", ld, 32'hBEEF3344);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [31:0] a;
            logic [1:0]  sz;
            if (r < 7)      a = 32'($urandom_range(0, 127));
            else if (r < 9) a = 32'(MEM_BYTES - 8 + $urandom_range(0, 11));
            else            a = $urandom;
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, ld);
        end
        mem_compare("mem_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store sequencer that sits directly upstream of the byte-addressed, big-endian 32-bit data memory. It accepts one load/store request at a time from the pipeline and stalls the pipeline while the request is in progress. It issues word-aligned accesses to the memory and does read-modify-write for byte and halfword stores, because the memory writes only whole words. It extracts and sign- or zero-extends sub-word load data and flags misaligned or out-of-range accesses.

Parameters:
MEM_BYTES, 1024, size of the data memory in bytes; any access touching an address >= MEM_BYTES faults.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  memory request present; held stable by pipeline while stall=1
req_write  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  input  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified for byte/half
stall  output  1  pipeline hold
load_data  output  32  extended load result, valid while state=DONE
fault  output  1  misaligned/illegal/out-of-range, valid while state=DONE
mem_addr  output  32  word-aligned address to data memory (registered)
mem_wdata  output  32  write word to data memory (registered)
mem_we  output  1  data memory write enable (registered)
mem_rdata  input  32  combinational read data from data memory

Behaviour:
- Clock is clk; reset is resetn, asynchronous, active-low. Reset forces state=IDLE, mem_addr=0, mem_wdata=0, mem_we=0, load_data=0, fault=0 immediately. Reset during any state aborts the operation; an in-flight mem_we drops at once.
- States: IDLE, RD_WAIT, RMW_WAIT, WR, DONE.
- stall = req_valid & (state != DONE). The pipeline advances on the cycle stall=0.
- Bad request: req_size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr+bytes-1 >= MEM_BYTES.
- IDLE with req_valid=1:
  - Bad request -> DONE with fault=1. No memory access and mem_we stays 0.
  - Otherwise mem_addr <= {req_addr[31:2],2'b00}.
  - Load -> RD_WAIT.
  - Word store -> WR, with mem_wdata<=req_wdata and mem_we<=1.
  - Byte/half store -> RMW_WAIT.
- RD_WAIT: sample mem_rdata on the clock edge and extract the lane.
  - Lanes are big-endian. Byte offset 0=[31:24], 1=[23:16], 2=[15:8], 3=[7:0]. Half offset 0=[31:16], 2=[15:0].
  - Extend to 32 bits per req_signed and register into load_data. Next state DONE.
- RMW_WAIT: sample mem_rdata and replace the addressed lane with req_wdata[7:0] or [15:0]. Set mem_wdata<=merged word, mem_we<=1, next state WR.
- WR: mem_we=1 for exactly one cycle. On exit mem_we<=0, next state DONE.
- DONE: stall=0. load_data and fault are held. Next state is IDLE unconditionally, so back-to-back requests see one IDLE cycle.
- Latencies, counted as cycles from acceptance to DONE inclusive: fault 2, load 3, word store 3, sub-word store 4.
- fault is 0 for every non-faulting completion. load_data is 0 for stores and faults.
- If req_valid drops mid-operation, the operation still completes, including the write. Inputs are sampled only in IDLE, RD_WAIT and RMW_WAIT.
- mem_addr holds its last value when idle. Memory read delay must be less than one clock period.

Test Plan:
- Preload word 0x08 = 0x11223344. Word load addr 0x08 -> stall 2 cycles, load_data=0x11223344, fault=0, mem_we never 1.
- With 0x8899AABB at 0x10, lb addr 0x11 (signed) -> load_data=0xFFFFFF99. lbu addr 0x11 -> 0x00000099. lh addr 0x12 -> 0xFFFFAABB. lhu addr 0x10 -> 0x00008899.
- sb addr 0x0E data 0x000000CC over 0x11223344 at 0x0C -> one mem_we pulse with mem_wdata=0x1122CC44. A subsequent word load returns 0x1122CC44.
- sh addr 0x0C data 0x0000BEEF, then sw addr 0x20 data 0xDEADBEEF -> memory holds 0xBEEF3344 and 0xDEADBEEF. Stall lengths are 3 and 2 cycles.
- Faults: lw addr 0x06, lh addr 0x03, req_size=11, sw addr MEM_BYTES-2 -> each gives fault=1 in DONE after 1 stall cycle, mem_we=0, memory unchanged.
- Assert resetn=0 while in WR during a sb -> mem_we drops immediately, state returns to IDLE, stall follows req_valid. After release, a new lw completes normally.
